// File: rtl/picorv32_tcm_pkg.sv
// Shared types, limits and the round-robin search helper for the multi-port TCM.
package picorv32_tcm_pkg;

    localparam int MAX_PORTS        = 8;
    localparam int MAX_READ_LATENCY = 3;
    localparam int PTR_W            = 3;

    typedef logic [3:0] wstrb_t;

    // Unused request bits are zero, so a cyclic search over MAX_PORTS gives the
    // same winner as a search over the configured port count.
    function automatic logic [MAX_PORTS-1:0] rr_next(input logic [MAX_PORTS-1:0] req,
                                                     input logic [PTR_W-1:0]     ptr);
        logic [MAX_PORTS-1:0] gnt;
        logic [PTR_W-1:0]     idx;
        logic                 found;
        gnt   = {MAX_PORTS{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/picorv32_tcm_mport_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer tracks the last winner.
module tcm_rr_arbiter
    import picorv32_tcm_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PTR_W-1:0]     grant_idx_o,
    output logic                 grant_valid_o
);

    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [MAX_PORTS-1:0] req_ext_s;
    logic [MAX_PORTS-1:0] gnt_ext_s;

    // Grant search and pointer next-state.
    always_comb begin
        req_ext_s                = {MAX_PORTS{1'b0}};
        req_ext_s[NUM_PORTS-1:0] = req_i;
        gnt_ext_s                = rr_next(req_ext_s, ptr_q);
        grant_o                  = gnt_ext_s[NUM_PORTS-1:0];
        grant_valid_o            = |gnt_ext_s;
        grant_idx_o              = {PTR_W{1'b0}};
        for (int k = 0; k < MAX_PORTS; k++) begin
            grant_idx_o |= gnt_ext_s[k] ? PTR_W'(k) : {PTR_W{1'b0}};
        end
        if (advance_i && grant_valid_o) begin
            ptr_d = grant_idx_o;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset value makes port 0 the first winner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PTR_W'(NUM_PORTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/picorv32_tcm_mport.sv
// Multi-port TCM: NUM_PORTS native-bus masters share one word RAM through a
// round-robin arbiter, with a READ_LATENCY-deep read pipeline.
module picorv32_tcm_mport
    import picorv32_tcm_pkg::*;
#(
    parameter int    ADDR_WIDTH    = 10,
    parameter int    NUM_PORTS     = 2,
    parameter int    READ_LATENCY  = 1,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            mem_valid,
    output logic [NUM_PORTS-1:0]            mem_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr,
    input  logic [NUM_PORTS*32-1:0]         mem_wdata,
    input  logic [NUM_PORTS*4-1:0]          mem_wstrb,
    output logic [NUM_PORTS*32-1:0]         mem_rdata,
    output logic [NUM_PORTS-1:0]            busy
);

    localparam int WORD_AW   = ADDR_WIDTH - 2;
    localparam int NUM_WORDS = 2 ** WORD_AW;

    logic [31:0]          mem_q [NUM_WORDS];
    logic [NUM_PORTS-1:0] busy_q;
    logic [NUM_PORTS-1:0] busy_d;
    logic [NUM_PORTS-1:0] req_s;
    logic [NUM_PORTS-1:0] grant_s;
    logic [PTR_W-1:0]     grant_idx_s;
    logic                 grant_valid_s;
    logic [WORD_AW-1:0]   sel_word_s;
    logic [31:0]          sel_wdata_s;
    wstrb_t               sel_wstrb_s;
    logic                 is_write_s;
    logic                 unused_addr_lsb_s;
    logic                 rd_vld_q  [READ_LATENCY];
    logic [PTR_W-1:0]     rd_idx_q  [READ_LATENCY];
    logic [31:0]          rd_data_q [READ_LATENCY];
    logic                 wr_vld_q;
    logic [PTR_W-1:0]     wr_idx_q;
    logic [31:0]          hold_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_done_s;
    logic [NUM_PORTS-1:0] wr_done_s;

    // A port already in flight is not eligible, even if it keeps valid high.
    always_comb begin
        req_s = mem_valid & ~busy_q;
    end

    tcm_rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arb (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_i        (req_s),
        .advance_i    (1'b1),
        .grant_o      (grant_s),
        .grant_idx_o  (grant_idx_s),
        .grant_valid_o(grant_valid_s)
    );

    // One-hot mux of the granted port's request onto the RAM.
    always_comb begin
        sel_word_s        = {WORD_AW{1'b0}};
        sel_wdata_s       = 32'h0;
        sel_wstrb_s       = 4'h0;
        unused_addr_lsb_s = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sel_word_s  |= grant_s[k] ? mem_addr[k*ADDR_WIDTH+2 +: WORD_AW] : {WORD_AW{1'b0}};
            sel_wdata_s |= grant_s[k] ? mem_wdata[k*32 +: 32] : 32'h0;
            sel_wstrb_s |= grant_s[k] ? mem_wstrb[k*4 +: 4] : 4'h0;
            unused_addr_lsb_s ^= ^mem_addr[k*ADDR_WIDTH +: 2];
        end
        is_write_s = |sel_wstrb_s;
    end

    // RAM array and read data pipeline; contents survive reset.
    always_ff @(posedge clock) begin
        if (grant_valid_s && is_write_s) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_wstrb_s[b]) begin
                    mem_q[sel_word_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
                end
            end
        end
        rd_data_q[0] <= mem_q[sel_word_s];
        for (int k = 1; k < READ_LATENCY; k++) begin
            rd_data_q[k] <= rd_data_q[k-1];
        end
    end

    // Completion decode, busy next-state and per-port read data hold mux.
    always_comb begin
        rd_done_s = {NUM_PORTS{1'b0}};
        wr_done_s = {NUM_PORTS{1'b0}};
        mem_rdata = {(NUM_PORTS*32){1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_done_s[i] = rd_vld_q[READ_LATENCY-1] && (rd_idx_q[READ_LATENCY-1] == PTR_W'(i));
            wr_done_s[i] = wr_vld_q && (wr_idx_q == PTR_W'(i));
            mem_rdata[i*32 +: 32] = rd_done_s[i] ? rd_data_q[READ_LATENCY-1] : hold_q[i];
        end
        mem_ready = rd_done_s | wr_done_s;
        busy      = busy_q;
        busy_d    = (busy_q & ~mem_ready) | grant_s;
    end

    // Control state: valid/index pipeline, write completion, busy and held data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_vld_q[k] <= 1'b0;
                rd_idx_q[k] <= {PTR_W{1'b0}};
            end
            wr_vld_q <= 1'b0;
            wr_idx_q <= {PTR_W{1'b0}};
            busy_q   <= {NUM_PORTS{1'b0}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                hold_q[i] <= 32'h0;
            end
        end else begin
            rd_vld_q[0] <= grant_valid_s && !is_write_s;
            rd_idx_q[0] <= grant_idx_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                rd_idx_q[k] <= rd_idx_q[k-1];
            end
            wr_vld_q <= grant_valid_s && is_write_s;
            wr_idx_q <= grant_idx_s;
            busy_q   <= busy_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (rd_done_s[i]) begin
                    hold_q[i] <= rd_data_q[READ_LATENCY-1];
                end
            end
        end
    end

endmodule
